// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a small write FIFO.
// Characters pushed through the valid/ready port are serialised back-to-back,
// LSB first, with a per-frame latched bit period.
// Optional parity bit: define UART_TX_PARITY_EN to add parity_en_i/parity_odd_i
// and the PARITY state; without it frames are start + data + stop only.
module uart_tx_fifo #(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1,
    parameter int DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       rstn_i,
    input  logic [31:0]                clk_div_i,
    input  logic [DATA_BITS-1:0]       wr_data_i,
    input  logic                       wr_valid_i,
    output logic                       wr_ready_o,
    input  logic                       flush_i,
`ifdef UART_TX_PARITY_EN
    input  logic                       parity_en_i,
    input  logic                       parity_odd_i,
`endif
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    output logic                       busy_o,
    output logic                       tx_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);
    localparam int IDX_W = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [DATA_BITS-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wptr;
    logic [PTR_W-1:0]     r_rptr;
    logic [LVL_W-1:0]     r_level;

    state_t               r_state;
    logic [31:0]          r_cnt;
    logic [31:0]          r_bitCyc;
    logic [IDX_W-1:0]     r_bitIdx;
    logic                 r_stopIdx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_tx;
    logic                 r_busy;
`ifdef UART_TX_PARITY_EN
    logic                 r_parEn;
    logic                 r_parBit;
`endif

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_bitEnd;
    logic                 w_stopEnd;
    logic [31:0]          w_bitCyc;
    logic [DATA_BITS-1:0] w_head;

    assign w_full    = (r_level == LVL_W'(DEPTH));
    assign w_empty   = (r_level == '0);
    assign w_push    = wr_valid_i && !w_full && !flush_i;
    assign w_bitEnd  = (r_cnt == r_bitCyc - 32'd1);
    assign w_stopEnd = (r_state == S_STOP) && w_bitEnd && (r_stopIdx == 1'(STOP_BITS-1));
    assign w_pop     = !w_empty && ((r_state == S_IDLE) || w_stopEnd);
    assign w_bitCyc  = (clk_div_i == 32'd0) ? 32'd1 : clk_div_i;
    assign w_head    = r_mem[r_rptr];

    assign wr_ready_o = !w_full;
    assign level_o    = r_level;
    assign busy_o     = r_busy;
    assign tx_o       = r_tx;

    // FIFO storage: write the incoming character at the write pointer
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= wr_data_i;
        end
    end

    // FIFO pointers and occupancy; flush discards everything and drops a same-cycle push
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else if (flush_i) begin
            r_rptr  <= r_wptr;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Transmit FSM with registered tx/busy; a pop always launches a new start bit
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bitCyc  <= 32'd1;
            r_bitIdx  <= '0;
            r_stopIdx <= 1'b0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parEn   <= 1'b0;
            r_parBit  <= 1'b0;
`endif
        end else if (w_pop) begin
            r_state   <= S_START;
            r_cnt     <= '0;
            r_bitCyc  <= w_bitCyc;
            r_bitIdx  <= '0;
            r_stopIdx <= 1'b0;
            r_shift   <= w_head;
            r_tx      <= 1'b0;
            r_busy    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parEn   <= parity_en_i;
            r_parBit  <= (^w_head) ^ parity_odd_i;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                end
                S_START: begin
                    if (w_bitEnd) begin
                        r_cnt   <= '0;
                        r_state <= S_DATA;
                        r_tx    <= r_shift[0];
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_DATA: begin
                    if (w_bitEnd) begin
                        r_cnt <= '0;
                        if (r_bitIdx == IDX_W'(DATA_BITS-1)) begin
`ifdef UART_TX_PARITY_EN
                            if (r_parEn) begin
                                r_state <= S_PARITY;
                                r_tx    <= r_parBit;
                            end else begin
                                r_state <= S_STOP;
                                r_tx    <= 1'b1;
                            end
`else
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
`endif
                        end else begin
                            r_bitIdx <= r_bitIdx + IDX_W'(1);
                            r_shift  <= r_shift >> 1;
                            r_tx     <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_bitEnd) begin
                        r_cnt   <= '0;
                        r_state <= S_STOP;
                        r_tx    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
`endif
                S_STOP: begin
                    if (w_bitEnd) begin
                        r_cnt <= '0;
                        if (r_stopIdx == 1'(STOP_BITS-1)) begin
                            r_state <= S_IDLE;
                            r_tx    <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_stopIdx <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
